// File: rtl/grid_cursor_plotter_if.sv
// Box-draw request channel between the cursor plotter and the VGA box plotter.
interface grid_cursor_plotter_if #(
  parameter int XW = 8,
  parameter int YW = 8
) ();
  logic          draw_req;
  logic          draw_ready;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [2:0]    colour;
  logic          draw_full;

  modport master (output draw_req, x, y, colour, draw_full, input draw_ready);
  modport slave  (input draw_req, x, y, colour, draw_full, output draw_ready);
endinterface

// File: rtl/grid_cursor_plotter.sv
// Grid cursor plotter: walks a cursor over a ROWS x COLS symbol grid, turns
// each cell into pixel coordinates and issues box-draw requests. A wrong
// input erases the current column back to row 0; filling the grid parks the
// block in FULL until clear or reset.
module grid_cursor_plotter #(
  parameter int ROWS     = 5,
  parameter int COLS     = 6,
  parameter int CELL_W   = 9,
  parameter int CELL_H   = 8,
  parameter int ORIGIN_X = 20,
  parameter int ORIGIN_Y = 30,
  parameter int XW       = 8,
  parameter int YW       = 8,
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   step,
  input  logic                   correct,
  input  logic [1:0]             selection,
  input  logic                   clear,
  grid_cursor_plotter_if.master  draw,
  output logic [RW-1:0]          row,
  output logic [CW-1:0]          column,
  output logic                   busy,
  output logic                   done
);

  localparam int PW = ((XW > YW) ? XW : YW) + ((RW > CW) ? RW : CW);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_ERASE, S_FULL} state_t;

  state_t        r_state, w_state_nx;
  logic [RW-1:0] r_row, w_row_nx;
  logic [RW-1:0] r_e, w_e_nx;
  logic [CW-1:0] r_col, w_col_nx;
  logic [XW-1:0] r_x, w_x_nx;
  logic [YW-1:0] r_y, w_y_nx;
  logic [2:0]    r_colour, w_colour_nx;
  logic          r_full, w_full_nx;
  logic          r_req, w_req_nx;
  logic          r_clr_pend, w_clr_pend_nx;
  logic          w_home;
  logic          w_accept;
  logic          w_clr;

  function automatic logic [XW-1:0] cell_x(input logic [CW-1:0] c);
    logic [PW-1:0] p;
    p = PW'(ORIGIN_X) + PW'(c) * PW'(CELL_W);
    return p[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] cell_y(input logic [RW-1:0] r);
    logic [PW-1:0] p;
    p = PW'(ORIGIN_Y) + PW'(r) * PW'(CELL_H);
    return p[YW-1:0];
  endfunction

  // {colour, filled} for each selection code
  function automatic logic [3:0] sel_decode(input logic [1:0] s);
    case (s)
      2'b00:   return 4'b100_1;
      2'b01:   return 4'b111_1;
      2'b11:   return 4'b111_0;
      default: return 4'b000_1;
    endcase
  endfunction

  assign w_accept = r_req & draw.draw_ready;
  assign w_clr    = clear | r_clr_pend;

  // Next-state and datapath update; clear during a handshake is remembered
  // and applied at the accept edge, abandoning any remaining erase cells.
  always_comb begin
    w_state_nx    = r_state;
    w_row_nx      = r_row;
    w_col_nx      = r_col;
    w_e_nx        = r_e;
    w_x_nx        = r_x;
    w_y_nx        = r_y;
    w_colour_nx   = r_colour;
    w_full_nx     = r_full;
    w_req_nx      = r_req;
    w_clr_pend_nx = r_clr_pend;
    w_home        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (clear) begin
          w_home = 1'b1;
        end else if (step) begin
          if (correct) begin
            w_x_nx                   = cell_x(r_col);
            w_y_nx                   = cell_y(r_row);
            {w_colour_nx, w_full_nx} = sel_decode(selection);
            w_req_nx                 = 1'b1;
            w_state_nx               = S_DRAW;
          end else if (r_row != '0) begin
            w_e_nx      = '0;
            w_x_nx      = cell_x(r_col);
            w_y_nx      = cell_y('0);
            w_colour_nx = 3'b000;
            w_full_nx   = 1'b1;
            w_req_nx    = 1'b1;
            w_state_nx  = S_ERASE;
          end
        end
      end
      S_DRAW: begin
        if (clear) w_clr_pend_nx = 1'b1;
        if (w_accept) begin
          w_req_nx = 1'b0;
          if (w_clr) begin
            w_home = 1'b1;
          end else if (r_row != RW'(ROWS - 1)) begin
            w_row_nx   = r_row + RW'(1);
            w_state_nx = S_IDLE;
          end else if (r_col != CW'(COLS - 1)) begin
            w_row_nx   = '0;
            w_col_nx   = r_col + CW'(1);
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_FULL;
          end
        end
      end
      S_ERASE: begin
        if (clear) w_clr_pend_nx = 1'b1;
        if (w_accept) begin
          if (w_clr) begin
            w_home = 1'b1;
          end else if (r_e == r_row - RW'(1)) begin
            w_req_nx   = 1'b0;
            w_row_nx   = '0;
            w_state_nx = S_IDLE;
          end else begin
            // back-to-back: next cell request presented straight after accept
            w_e_nx = r_e + RW'(1);
            w_y_nx = cell_y(r_e + RW'(1));
          end
        end
      end
      S_FULL: begin
        if (clear) w_home = 1'b1;
      end
      default: w_home = 1'b1;
    endcase
    if (w_home) begin
      w_state_nx    = S_IDLE;
      w_row_nx      = '0;
      w_col_nx      = '0;
      w_e_nx        = '0;
      w_x_nx        = XW'(ORIGIN_X);
      w_y_nx        = YW'(ORIGIN_Y);
      w_colour_nx   = 3'b000;
      w_full_nx     = 1'b0;
      w_req_nx      = 1'b0;
      w_clr_pend_nx = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_e        <= '0;
      r_x        <= XW'(ORIGIN_X);
      r_y        <= YW'(ORIGIN_Y);
      r_colour   <= 3'b000;
      r_full     <= 1'b0;
      r_req      <= 1'b0;
      r_clr_pend <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_row      <= w_row_nx;
      r_col      <= w_col_nx;
      r_e        <= w_e_nx;
      r_x        <= w_x_nx;
      r_y        <= w_y_nx;
      r_colour   <= w_colour_nx;
      r_full     <= w_full_nx;
      r_req      <= w_req_nx;
      r_clr_pend <= w_clr_pend_nx;
    end
  end

  assign draw.draw_req  = r_req;
  assign draw.x         = r_x;
  assign draw.y         = r_y;
  assign draw.colour    = r_colour;
  assign draw.draw_full = r_full;
  assign row            = r_row;
  assign column         = r_col;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_FULL);

endmodule

// File: tb/tb_grid_cursor_plotter.sv
// Bench for grid_cursor_plotter: a cell-level cursor model predicts every
// box-draw request into a queue; a monitor pops and compares on each accept.
module tb_grid_cursor_plotter;
  localparam int ROWS = 5, COLS = 6, CELL_W = 9, CELL_H = 8, OX = 20, OY = 30;

  logic       clock = 1'b0;
  logic       reset, step, correct, clear;
  logic [1:0] selection;
  logic [2:0] row, column;
  logic       busy, done;

  grid_cursor_plotter_if #(.XW(8), .YW(8)) bus ();

  grid_cursor_plotter #(
    .ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .CELL_H(CELL_H),
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .XW(8), .YW(8)
  ) dut (
    .clock(clock), .reset(reset), .step(step), .correct(correct),
    .selection(selection), .clear(clear), .draw(bus),
    .row(row), .column(column), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] c;
    logic       f;
  } req_t;

  req_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_row = 0, m_col = 0;
  bit   m_full = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: hold low, 3: toggle

  int colour_of[4] = '{4, 7, 0, 7};
  int filled_of[4] = '{1, 1, 1, 0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic req_t cell_req(input int r, input int c, input int colour, input int f);
    req_t q;
    q.x = 8'(OX + c * CELL_W);
    q.y = 8'(OY + r * CELL_H);
    q.c = 3'(colour);
    q.f = 1'(f);
    return q;
  endfunction

  // Cell-level model of one accepted step event
  task automatic model_step(input bit corr, input logic [1:0] sel);
    if (exp_q.size() != 0 || m_full) return;  // busy: step dropped
    if (corr) begin
      exp_q.push_back(cell_req(m_row, m_col, colour_of[sel], filled_of[sel]));
      if (m_row < ROWS - 1) m_row++;
      else if (m_col < COLS - 1) begin m_row = 0; m_col++; end
      else m_full = 1;
    end else if (m_row != 0) begin
      for (int e = 0; e < m_row; e++) exp_q.push_back(cell_req(e, m_col, 0, 1));
      m_row = 0;
    end
  endtask

  task automatic do_step(input bit corr, input logic [1:0] sel);
    step = 1'b1; correct = corr; selection = sel;
    model_step(corr, sel);
    @(posedge clock); #1;
    step = 1'b0;
    selection = 2'($urandom);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) begin ok = 1; break; end
      @(posedge clock); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_idle: %0d requests still outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_row"}, int'(row), m_row);
    chk({tag, "_col"}, int'(column), m_col);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, int'(bus.draw_req), 0);
    chk({tag, "_x"}, int'(bus.x), OX);
    chk({tag, "_y"}, int'(bus.y), OY);
    chk({tag, "_colour"}, int'(bus.colour), 0);
    chk({tag, "_full"}, int'(bus.draw_full), 0);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_col"}, int'(column), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  // Ready generator
  initial begin
    bit tog = 0;
    bus.draw_ready = 1'b0;
    forever begin
      @(posedge clock); #2;
      tog = ~tog;
      case (ready_mode)
        0: bus.draw_ready = 1'b1;
        1: bus.draw_ready = 1'($urandom);
        2: bus.draw_ready = 1'b0;
        default: bus.draw_ready = tog;
      endcase
    end
  end

  // Monitor: compare each accepted request and hold-stability while stalled
  initial begin
    req_t cur, prev, e;
    bit   prev_pend = 0;
    prev = '0;
    forever begin
      @(negedge clock);
      if (reset) begin prev_pend = 0; continue; end
      cur = {bus.x, bus.y, bus.colour, bus.draw_full};
      if (prev_pend) begin
        checks++;
        if (!bus.draw_req) begin
          errors++;
          $display("FAIL req_hold: draw_req=0 while stalled, required 1");
        end else if (cur != prev) begin
          errors++;
          $display("FAIL req_stable: got %h required %h", cur, prev);
        end
      end
      if (bus.draw_req && bus.draw_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req: x=%0d y=%0d c=%b f=%b, required no request",
                   cur.x, cur.y, cur.c, cur.f);
        end else begin
          e = exp_q.pop_front();
          if (cur != e) begin
            errors++;
            $display("FAIL req_fields: got x=%0d y=%0d c=%b f=%b required x=%0d y=%0d c=%b f=%b",
                     cur.x, cur.y, cur.c, cur.f, e.x, e.y, e.c, e.f);
          end
        end
      end
      prev_pend = bus.draw_req && !bus.draw_ready;
      prev = cur;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; step = 1'b0; correct = 1'b0; clear = 1'b0; selection = 2'b00;
    @(posedge clock); #1;
    chk_reset_vals("reset");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // First draw, then rest of column 0, then first cell of column 1
    do_step(1'b1, 2'b00);
    wait_idle(); chk_cursor("first");
    for (int i = 0; i < 4; i++) begin do_step(1'b1, 2'($urandom)); wait_idle(); end
    chk_cursor("col_wrap");
    do_step(1'b1, 2'b01); wait_idle();
    do_step(1'b1, 2'b01); wait_idle();
    do_step(1'b1, 2'b00); wait_idle();
    chk_cursor("row3");

    // Erase three cells with toggling ready
    ready_mode = 3;
    do_step(1'b0, 2'b00); wait_idle();
    chk_cursor("erase");

    // Step while stalled is dropped; outline and black modes
    ready_mode = 2;
    do_step(1'b1, 2'b11);
    repeat (2) @(posedge clock); #1;
    do_step(1'b1, 2'b00);
    ready_mode = 0;
    wait_idle(); chk_cursor("drop");
    do_step(1'b1, 2'b10); wait_idle();

    // clear coincident with step in IDLE: clear wins
    step = 1'b1; correct = 1'b1; clear = 1'b1;
    @(posedge clock); #1;
    step = 1'b0; clear = 1'b0;
    m_row = 0; m_col = 0;
    @(posedge clock); #1;
    chk_cursor("clr_step"); chk("clr_step_busy", int'(busy), 0);

    // clear during a stalled draw
    ready_mode = 2;
    do_step(1'b1, 2'b01);
    pulse_clear();
    m_row = 0; m_col = 0;
    ready_mode = 1;
    wait_idle(); chk_cursor("clr_draw");

    // clear during erase abandons remaining cells
    ready_mode = 0;
    for (int i = 0; i < 3; i++) begin do_step(1'b1, 2'($urandom)); wait_idle(); end
    ready_mode = 2;
    do_step(1'b0, 2'b00);
    pulse_clear();
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    m_row = 0; m_col = 0;
    ready_mode = 1;
    wait_idle(); chk_cursor("clr_erase");

    // Reset during a pending request
    ready_mode = 2;
    do_step(1'b1, 2'b00);
    chk("pre_reset_req", int'(bus.draw_req), 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    exp_q.delete(); m_row = 0; m_col = 0; m_full = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    ready_mode = 1;
    @(posedge clock); #1;

    // Random mix of steps, then fill the grid
    for (int i = 0; i < 300 && !m_full; i++) begin
      do_step(($urandom % 6) != 0, 2'($urandom));
      repeat ($urandom % 4) begin @(posedge clock); #1; end
    end
    for (int i = 0; i < 200 && !m_full; i++) begin
      wait_idle(); do_step(1'b1, 2'($urandom));
    end
    wait_idle();
    chk("full_done", int'(done), 1);
    chk("full_busy", int'(busy), 1);
    for (int i = 0; i < 4; i++) begin do_step(1'b1, 2'($urandom)); end
    repeat (8) begin @(posedge clock); #1; end
    chk("full_hold", int'(done), 1);
    pulse_clear();
    m_row = 0; m_col = 0; m_full = 0;
    chk("clr_done", int'(done), 0);
    chk("clr_busy", int'(busy), 0);
    chk_cursor("clr_full");
    do_step(1'b1, 2'b11); wait_idle();
    chk_cursor("after_full");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
